ultrasonic_ranger: RTL

- Drives an HC-SR04-style ultrasonic sensor: issues trigger pulses and times the echo pulse width.
- Converts echo width to an 8-bit distance in centimetres.
- This is the producer of the `distance` bus that the beeper/alarm logic consumes.
- Sits between the sensor GPIO pins and the alarm block; runs continuously while enabled.

---
 rtl/ultrasonic_ranger.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo timer producing distance in cm.
// Defining RANGE_MEDIAN3_EN reports the median of the three newest results instead of the raw one.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES   = 500,
  parameter int CYCLES_PER_CM = 2900,
  parameter int ECHO_TIMEOUT  = 1500000,
  parameter int PERIOD_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       echo,
  output logic       trig,
  output logic [7:0] distance,
  output logic       valid,
  output logic       timeout_err
);
  localparam logic [2:0] IDLE = 3'd0, TRIG = 3'd1, WAIT_RISE = 3'd2, MEASURE = 3'd3, DONE = 3'd4;
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int OW = $clog2(ECHO_TIMEOUT + 1);
  localparam int SW = $clog2(CYCLES_PER_CM + 1);
  if (TRIG_CYCLES + ECHO_TIMEOUT + 8 >= PERIOD_CYCLES) begin : g_bad_params
    $error("ultrasonic_ranger: measurement does not fit in one trigger period");
  end
  logic [2:0]    state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [OW-1:0] to_q, to_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [7:0]    cm_q, cm_d, cm_inc, raw, distance_q, distance_d;
  logic          valid_q, valid_d, terr_q, terr_d;
  logic          s1_q, s2_q, s3_q, rise, fall, to_hit, sub_wrap, fin, tout, upd;
`ifdef RANGE_MEDIAN3_EN
  logic [1:0][7:0] hist_q, hist_d;
  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] lo, hi;
    lo = a < b ? a : b;
    hi = a < b ? b : a;
    return c > hi ? hi : c < lo ? lo : c;
  endfunction
`endif
  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
    to_hit = to_q == OW'(ECHO_TIMEOUT - 1);
    sub_wrap = sub_q == SW'(CYCLES_PER_CM - 1);
    cm_inc = (sub_wrap && cm_q != 8'hff) ? cm_q + 8'd1 : cm_q;
    per_d = (!enable || per_q == PW'(PERIOD_CYCLES - 1)) ? '0 : per_q + PW'(1);
    state_d = state_q;
    tcnt_d = tcnt_q;
    to_d = to_q;
    sub_d = sub_q;
    cm_d = cm_q;
    fin = 1'b0;
    tout = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = (enable && per_q == '0) ? TRIG : IDLE;
        tcnt_d = '0;
      end
      TRIG: begin
        tcnt_d = tcnt_q + TW'(1);
        to_d = '0;
        state_d = tcnt_q == TW'(TRIG_CYCLES - 1) ? WAIT_RISE : TRIG;
      end
      WAIT_RISE: begin
        to_d = to_q + OW'(1);
        tout = to_hit;
        sub_d = '0;
        cm_d = '0;
        state_d = to_hit ? IDLE : rise ? MEASURE : WAIT_RISE;
      end
      MEASURE: begin
        to_d = to_q + OW'(1);
        sub_d = sub_wrap ? '0 : sub_q + SW'(1);
        cm_d = cm_inc;
        fin = fall;
        tout = to_hit & ~fall;
        state_d = fall ? DONE : to_hit ? IDLE : MEASURE;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
    upd = (fin | tout) & enable;
    raw = tout ? 8'hff : cm_inc;
    valid_d = upd;
    terr_d = upd ? tout : terr_q;
`ifdef RANGE_MEDIAN3_EN
    hist_d = upd ? {hist_q[0], raw} : hist_q;
    distance_d = upd ? med3(hist_q[1], hist_q[0], raw) : distance_q;
`else
    distance_d = upd ? raw : distance_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      per_q <= '0;
      tcnt_q <= '0;
      to_q <= '0;
      sub_q <= '0;
      cm_q <= '0;
      distance_q <= 8'hff;
      valid_q <= 1'b0;
      terr_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
`ifdef RANGE_MEDIAN3_EN
      hist_q <= '1;
`endif
    end else begin
      state_q <= state_d;
      per_q <= per_d;
      tcnt_q <= tcnt_d;
      to_q <= to_d;
      sub_q <= sub_d;
      cm_q <= cm_d;
      distance_q <= distance_d;
      valid_q <= valid_d;
      terr_q <= terr_d;
      s1_q <= echo;
      s2_q <= s1_q;
      s3_q <= s2_q;
`ifdef RANGE_MEDIAN3_EN
      hist_q <= hist_d;
`endif
    end
  end
  assign trig = state_q == TRIG;
  assign distance = distance_q;
  assign valid = valid_q;
  assign timeout_err = terr_q;
endmodule
